spi_master_gen: RTL

Parametrised SPI master and the successor of the current 8-bit, single-slave, mode-0 SPI block. It drains framed command/data words from a first-word-fall-through TX FIFO, drives one of several chip selects, and shifts words of configurable width in any CPOL/CPHA mode. It supports write-only, read-only and full-duplex frames, and pushes received words into an RX FIFO. It sits between the system FIFOs and the off-chip SPI pins, with the same FIFO-side handshake as today.

---
 rtl/spi_gen_pkg.sv | 34 +++
 rtl/spi_master_gen_clkgen.sv | 39 +++
 rtl/spi_master_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_gen_pkg.sv
// Shared constants for spi_master_gen: FSM state codes, frame-mode codes and
// command-word field positions derived from the data width.
package spi_gen_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCmd   = 3'd1;
    localparam logic [2:0] StSetup = 3'd2;
    localparam logic [2:0] StLoad  = 3'd3;
    localparam logic [2:0] StShift = 3'd4;
    localparam logic [2:0] StStall = 3'd5;
    localparam logic [2:0] StHold  = 3'd6;
    localparam logic [2:0] StGap   = 3'd7;

    localparam logic [1:0] MODE_WR = 2'b00;
    localparam logic [1:0] MODE_RD = 2'b01;
    localparam logic [1:0] MODE_FD = 2'b10;

    function automatic int unsigned cmd_flag_pos(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned mode_hi_pos(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned mode_lo_pos(input int unsigned dw);
        return dw - 2;
    endfunction

    function automatic int unsigned count_hi_pos(input int unsigned dw);
        return dw - 3;
    endfunction

endpackage

// File: rtl/spi_master_gen_clkgen.sv
// Half-period divider for spi_master_gen: edge strobes (valid only while running
// a word) plus the raw SCK level derived from the latched CPOL.
module spi_clkgen #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sck_lvl
);

    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;

    assign tick    = (cnt_q == div);
    assign lead    = run & tick & ~phase_q;
    assign trail   = run & tick & phase_q;
    assign sck_lvl = cpol ^ phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (run && tick) phase_q <= ~phase_q;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Framed SPI master: drains command/data words from a FWFT TX FIFO, any CPOL/CPHA.
// Define SPI_LSB_FIRST_EN to add the cfg_lsb_first port for LSB-first transfers.
module spi_master_gen #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CS_N  = 1,
    parameter int unsigned DIV_W = 4,
    localparam int unsigned CSW  = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW:0]      din,
    input  logic             tx_fifo_empty,
    output logic             tx_fifo_rd,
    output logic [DW-1:0]    dout,
    input  logic             rx_fifo_full,
    output logic             rx_fifo_wr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic             cfg_lsb_first,
`endif
    input  logic [CSW-1:0]   cfg_cs_sel,
    output logic [CS_N-1:0]  cs_n,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             busy
);
    import spi_gen_pkg::*;

    localparam int unsigned FlagPos = cmd_flag_pos(DW);
    localparam int unsigned ModeHi  = mode_hi_pos(DW);
    localparam int unsigned ModeLo  = mode_lo_pos(DW);
    localparam int unsigned CntHi   = count_hi_pos(DW);
    localparam int unsigned NW      = DW - 2;
    localparam int unsigned BW      = $clog2(DW);

    logic [2:0]       state_q, state_d;
    logic [1:0]       mode_q;
    logic [NW-1:0]    cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             cpol_q, cpha_q, lsb_q, lsb_in;
    logic [CSW-1:0]   cs_sel_q;
    logic [BW-1:0]    bit_q;
    logic [DW-1:0]    tx_sr_q, rx_sr_q, dout_q;
    logic             mosi_q, wr_q;
    logic [CS_N-1:0]  cs_n_q;

    logic             tick, lead, trail, sck_raw;
    logic             need_tx, need_rx, ready, last_bit, shift_ev, sample_ev;
    logic [DW-1:0]    load_word, tx_next, rx_next;
    logic [1:0]       cmd_mode;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = cfg_lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .run     (state_q == StShift),
        .div     (div_q),
        .cpol    (cpol_q),
        .tick    (tick),
        .lead    (lead),
        .trail   (trail),
        .sck_lvl (sck_raw)
    );

    // Mode is stored normalised, so 2'b11 never reaches the datapath.
    assign cmd_mode  = din[ModeHi:ModeLo];
    assign need_tx   = (mode_q != MODE_RD);
    assign need_rx   = (mode_q != MODE_WR);
    assign ready     = (!need_tx || !tx_fifo_empty) && (!need_rx || !rx_fifo_full);
    assign last_bit  = (bit_q == BW'(DW - 1));
    assign shift_ev  = cpha_q ? (lead && (bit_q != '0)) : (trail && !last_bit);
    assign sample_ev = cpha_q ? trail : lead;
    assign load_word = need_tx ? din[DW-1:0] : '1;
    assign tx_next   = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
    assign rx_next   = lsb_q ? {miso, rx_sr_q[DW-1:1]} : {rx_sr_q[DW-2:0], miso};

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!tx_fifo_empty && din[FlagPos]) state_d = StCmd;
            StCmd:   state_d = (din[CntHi:0] == '0) ? StIdle : StSetup;
            StSetup: if (tick) state_d = StLoad;
            StLoad:  state_d = ready ? StShift : StStall;
            StStall: if (ready) state_d = StLoad;
            StShift: if (trail && last_bit) state_d = (cnt_q == NW'(1)) ? StHold : StLoad;
            StHold:  if (tick) state_d = StGap;
            StGap:   if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gated by rst so nothing is popped in the cycle a reset is sampled.
    always_comb begin
        tx_fifo_rd = 1'b0;
        if (!rst) begin
            if (state_q == StIdle)      tx_fifo_rd = !tx_fifo_empty && !din[FlagPos];
            else if (state_q == StCmd)  tx_fifo_rd = 1'b1;
            else if (state_q == StLoad) tx_fifo_rd = ready && need_tx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mode_q   <= MODE_WR;
            cnt_q    <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            cs_sel_q <= '0;
            bit_q    <= '0;
            tx_sr_q  <= '1;
            rx_sr_q  <= '0;
            dout_q   <= '0;
            mosi_q   <= 1'b1;
            wr_q     <= 1'b0;
            cs_n_q   <= '1;
        end else begin
            state_q <= state_d;
            wr_q    <= 1'b0;
            case (state_q)
                StCmd: begin
                    mode_q   <= (cmd_mode == MODE_RD || cmd_mode == MODE_FD) ? cmd_mode : MODE_WR;
                    cnt_q    <= din[CntHi:0];
                    div_q    <= cfg_div;
                    cpol_q   <= cfg_cpol;
                    cpha_q   <= cfg_cpha;
                    lsb_q    <= lsb_in;
                    cs_sel_q <= cfg_cs_sel;
                    if (din[CntHi:0] != '0) cs_n_q <= ~(CS_N'(1) << cfg_cs_sel);
                end
                StLoad: begin
                    if (ready) begin
                        tx_sr_q <= load_word;
                        mosi_q  <= lsb_q ? load_word[0] : load_word[DW-1];
                        bit_q   <= '0;
                    end
                end
                StShift: begin
                    if (shift_ev) begin
                        tx_sr_q <= tx_next;
                        mosi_q  <= lsb_q ? tx_next[0] : tx_next[DW-1];
                    end
                    if (sample_ev) begin
                        rx_sr_q <= rx_next;
                        if (last_bit && need_rx) begin
                            dout_q <= rx_next;
                            wr_q   <= 1'b1;
                        end
                    end
                    if (trail) begin
                        bit_q <= bit_q + 1'b1;
                        if (last_bit) cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    mosi_q <= 1'b1;
                    if (tick) cs_n_q <= '1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cs_n       = cs_n_q;
    assign sck        = sck_raw;
    assign mosi       = mosi_q;
    assign dout       = dout_q;
    assign rx_fifo_wr = wr_q;
    assign busy       = (state_q != StIdle);

endmodule
